// File: rtl/led_mmio_if.sv
// Core load/store request/response channel for the LED peripheral.
interface led_mmio_if #(
  parameter int ADDR_W = 5
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/led_mmio_responder.sv
// Memory-mapped LED peripheral: register file behind a valid/ready bus, driving
// registered LED pins with per-LED PWM dimming and a global blink gate.

module led_mmio_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       on,
  input  logic       pwm_en,
  input  logic [7:0] duty,
  input  logic [7:0] pwm_cnt,
  input  logic       blink_gate,
  output logic       led
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) led <= 1'b0;
    else      led <= on & (!pwm_en | (pwm_cnt < duty)) & blink_gate;
  end
endmodule

module led_mmio_responder #(
  parameter int ADDR_W   = 5,
  parameter int NUM_LEDS = 4,
  parameter int BLINK_W  = 24
) (
  input  logic                clk,
  input  logic                rst,
  led_mmio_if.slave           bus,
  output logic [NUM_LEDS-1:0] led
);
  typedef enum logic {IDLE, RESP} state_t;

  state_t               state, state_nxt;
  logic                 accept;
  logic [NUM_LEDS-1:0]  led_out;
  logic [3:0][7:0]      duty;
  logic [1:0]           ctrl;
  logic [BLINK_W-1:0]   blink;
  logic [31:0]          cycles;
  logic [7:0]           pwm_cnt;
  logic [BLINK_W-1:0]   blink_cnt;
  logic                 blink_phase;
  logic [2:0]           widx;
  logic                 mapped;
  logic [31:0]          rd_view;
  logic [31:0]          wmask;
  logic [31:0]          wr_merge;
  logic                 wr;
  logic                 blink_wr;
  logic                 unused;

  assign unused = ^bus.req_addr[1:0];
  assign widx   = bus.req_addr[4:2];

  // Two-process handshake FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: if (bus.req_valid) begin
        accept    = 1'b1;
        state_nxt = RESP;
      end
      RESP: if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);

  // 32-bit view of the addressed register; unimplemented bits read 0
  always_comb begin
    rd_view = '0;
    mapped  = 1'b1;
    case (widx)
      3'd0: rd_view[NUM_LEDS-1:0] = led_out;
      3'd1: rd_view = duty;
      3'd2: rd_view[1:0] = ctrl;
      3'd3: rd_view[BLINK_W-1:0] = blink;
      3'd4: rd_view = cycles;
      default: mapped = 1'b0;
    endcase
  end

  assign wmask    = {{8{bus.req_be[3]}}, {8{bus.req_be[2]}}, {8{bus.req_be[1]}}, {8{bus.req_be[0]}}};
  assign wr_merge = (rd_view & ~wmask) | (bus.req_wdata & wmask);
  assign wr       = accept & bus.req_we;
  assign blink_wr = wr & (widx == 3'd3) & (|bus.req_be);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_out   <= '0;
      duty      <= '0;
      ctrl      <= '0;
      blink     <= '0;
      cycles    <= '0;
      pwm_cnt   <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      cycles  <= cycles + 32'd1;
      pwm_cnt <= pwm_cnt + 8'd1;
      if (wr) begin
        case (widx)
          3'd0: led_out <= wr_merge[NUM_LEDS-1:0];
          3'd1: duty    <= wr_merge;
          3'd2: ctrl    <= wr_merge[1:0];
          3'd3: blink   <= wr_merge[BLINK_W-1:0];
          default: ;
        endcase
      end
      if (accept) begin
        bus.rsp_rdata <= bus.req_we ? 32'd0 : rd_view;
        bus.rsp_err   <= !mapped | (bus.req_we & (widx == 3'd4));
      end
    end
  end

  // Blink counter; a BLINK write restarts the count but keeps the phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (!ctrl[1] || blink == '0) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_wr) begin
      blink_cnt   <= '0;
    end else if (blink_cnt == blink - BLINK_W'(1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + BLINK_W'(1);
    end
  end

  genvar i;
  generate
    for (i = 0; i < NUM_LEDS; i++) begin : g_lane
      led_mmio_lane u_lane (
        .clk        (clk),
        .rst        (rst),
        .on         (led_out[i]),
        .pwm_en     (ctrl[0]),
        .duty       (duty[i]),
        .pwm_cnt    (pwm_cnt),
        .blink_gate (!ctrl[1] | blink_phase),
        .led        (led[i])
      );
    end
  endgenerate
endmodule
